// File: rtl/batch_load_engine_pkg.sv
// Shared constants, state encoding and header builders for the batch load engine.
// Record layout: word 0 batch header, then records of one header plus PKT_WORDS payload words.
package batch_load_engine_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int DATA_DEPTH    = 65536;
    localparam int ADDR_WIDTH    = $clog2(DATA_DEPTH);
    localparam int PKTS_PER_FLOW = 5;
    localparam int PKT_WORDS     = 8;
    localparam int REC_STRIDE    = 1 + PKT_WORDS;
    localparam int WOFF_W        = $clog2(PKT_WORDS + 1);
    localparam int REC_CNT_W     = 11;

    localparam logic [7:0]            MAGIC       = 8'h55;
    localparam logic [7:0]            LEN_MAX     = 8'd64;
    localparam logic [ADDR_WIDTH-1:0] RESULT_BASE = 16'hFFFC;

    localparam int HDR_LEN_LSB  = 32;
    localparam int HDR_FLOW_LSB = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_RECV,
        S_PAD,
        S_HDR,
        S_COMMIT,
        S_WAITCALC,
        S_READRES,
        S_DONE
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, k[i]};
        return c;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rec_header(input logic [7:0] len);
        logic [DATA_WIDTH-1:0] h;
        h = '0;
        h[7:0] = MAGIC;
        h[HDR_LEN_LSB +: 8] = len;
        return h;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] batch_header(input logic [7:0] flow);
        logic [DATA_WIDTH-1:0] h;
        h = '0;
        h[7:0] = MAGIC;
        h[HDR_FLOW_LSB +: 8] = flow;
        return h;
    endfunction

endpackage

// File: rtl/batch_load_engine_if.sv
// Packet beat stream into the batch load engine (ready/valid).
interface batch_load_engine_if;
    import batch_load_engine_pkg::*;

    logic [DATA_WIDTH-1:0] pkt_data;
    logic [7:0]            pkt_keep;
    logic                  pkt_valid;
    logic                  pkt_last;
    logic                  pkt_ready;

    modport master (output pkt_data, pkt_keep, pkt_valid, pkt_last, input pkt_ready);
    modport slave  (input pkt_data, pkt_keep, pkt_valid, pkt_last, output pkt_ready);

endinterface

// File: rtl/batch_load_addr_gen.sv
// Record base / payload word counters for the batch layout, plus the last-record compare.
module batch_load_addr_gen
    import batch_load_engine_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  start,
    input  logic [REC_CNT_W-1:0]  rec_total,
    input  logic                  word_inc,
    input  logic                  rec_inc,
    output logic [ADDR_WIDTH-1:0] rec_base,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  word_full,
    output logic                  pad_more,
    output logic                  last_rec
);

    logic [WOFF_W-1:0]    word_off;
    logic [REC_CNT_W-1:0] rec_idx;
    logic [REC_CNT_W-1:0] rec_total_q;

    // NOTE: registers are updated with non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rec_base    <= '0;
            word_off    <= '0;
            rec_idx     <= '0;
            rec_total_q <= '0;
        end else if (start) begin
            rec_base    <= ADDR_WIDTH'(1);
            word_off    <= '0;
            rec_idx     <= '0;
            rec_total_q <= rec_total;
        end else if (rec_inc) begin
            rec_base <= rec_base + ADDR_WIDTH'(REC_STRIDE);
            rec_idx  <= rec_idx + REC_CNT_W'(1);
            word_off <= '0;
        end else if (word_inc && !word_full) begin
            word_off <= word_off + WOFF_W'(1);
        end
    end

    // Beat index saturates at PKT_WORDS so oversize packets stay pinned at "full".
    assign word_full = (word_off >= WOFF_W'(PKT_WORDS));
    assign pad_more  = (word_off < WOFF_W'(PKT_WORDS - 1));
    assign wr_addr   = rec_base + ADDR_WIDTH'(1) + ADDR_WIDTH'(word_off);
    assign last_rec  = (rec_idx == rec_total_q - REC_CNT_W'(1));

endmodule

// File: rtl/batch_load_engine.sv
// Writes packet beats into BRAM port A as batch records, commits via word 0, then reads back results.
// Define BATCH_LOAD_PAD_EN to zero-fill unused payload words of short packets.
module batch_load_engine
    import batch_load_engine_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_batch_start,
    input  logic [7:0]              i_batch_flow_num,
    batch_load_engine_if.slave      pkt,
    output logic [ADDR_WIDTH-1:0]   o_bram_porta_addr,
    output logic [DATA_WIDTH-1:0]   o_bram_porta_din,
    output logic                    o_bram_porta_en,
    output logic [7:0]              o_bram_porta_we,
    input  logic [DATA_WIDTH-1:0]   i_bram_porta_dout,
    input  logic                    i_calc_complete,
    output logic [DATA_WIDTH-1:0]   o_result,
    output logic                    o_result_valid,
    output logic [1:0]              o_result_idx,
    output logic                    o_busy,
    output logic                    o_trunc
);

`ifdef BATCH_LOAD_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    state_t               state;
    logic [7:0]           flow_num;
    logic [7:0]           byte_len;
    logic                 calc_q;
    logic [2:0]           rd_step;
    logic                 beat_acc;
    logic                 gen_start;
    logic                 word_inc;
    logic                 rec_inc;
    logic [REC_CNT_W-1:0] rec_total;
    logic [ADDR_WIDTH-1:0] rec_base;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                 word_full;
    logic                 pad_more;
    logic                 last_rec;
    logic [8:0]           len_sum;
    logic [7:0]           len_next;

    assign beat_acc  = pkt.pkt_valid && pkt.pkt_ready;
    assign gen_start = (state == S_IDLE) && i_batch_start;
    assign word_inc  = ((state == S_RECV) && beat_acc) || (state == S_PAD);
    assign rec_inc   = (state == S_HDR);
    assign rec_total = REC_CNT_W'(({3'd0, i_batch_flow_num} + REC_CNT_W'(1)) * REC_CNT_W'(PKTS_PER_FLOW));
    assign len_sum   = {1'b0, byte_len} + {5'd0, popcount8(pkt.pkt_keep)};
    assign len_next  = (len_sum > {1'b0, LEN_MAX}) ? LEN_MAX : len_sum[7:0];

    batch_load_addr_gen u_addr_gen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .start     (gen_start),
        .rec_total (rec_total),
        .word_inc  (word_inc),
        .rec_inc   (rec_inc),
        .rec_base  (rec_base),
        .wr_addr   (wr_addr),
        .word_full (word_full),
        .pad_more  (pad_more),
        .last_rec  (last_rec)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= S_IDLE;
            flow_num          <= '0;
            byte_len          <= '0;
            calc_q            <= 1'b0;
            rd_step           <= '0;
            pkt.pkt_ready     <= 1'b0;
            o_bram_porta_addr <= '0;
            o_bram_porta_din  <= '0;
            o_bram_porta_en   <= 1'b0;
            o_bram_porta_we   <= '0;
            o_result          <= '0;
            o_result_valid    <= 1'b0;
            o_result_idx      <= '0;
            o_busy            <= 1'b0;
            o_trunc           <= 1'b0;
        end else begin
            calc_q         <= i_calc_complete;
            o_result_valid <= 1'b0;
            case (state)
                S_IDLE: if (i_batch_start) begin
                    flow_num          <= i_batch_flow_num;
                    byte_len          <= '0;
                    o_trunc           <= 1'b0;
                    o_busy            <= 1'b1;
                    o_bram_porta_en   <= 1'b1;
                    o_bram_porta_we   <= 8'hFF;
                    o_bram_porta_addr <= '0;
                    o_bram_porta_din  <= '0;
                    state             <= S_CLEAR;
                end
                S_CLEAR: begin
                    o_bram_porta_en <= 1'b0;
                    o_bram_porta_we <= '0;
                    pkt.pkt_ready   <= 1'b1;
                    state           <= S_RECV;
                end
                S_RECV: begin
                    o_bram_porta_en <= 1'b0;
                    o_bram_porta_we <= '0;
                    if (beat_acc) begin
                        byte_len <= len_next;
                        if (!word_full) begin
                            o_bram_porta_en   <= 1'b1;
                            o_bram_porta_we   <= 8'hFF;
                            o_bram_porta_addr <= wr_addr;
                            o_bram_porta_din  <= pkt.pkt_data;
                        end else begin
                            o_trunc <= 1'b1;
                        end
                        if (pkt.pkt_last) begin
                            pkt.pkt_ready <= 1'b0;
                            state         <= (PAD_EN && pad_more) ? S_PAD : S_HDR;
                        end
                    end
                end
                S_PAD: begin
                    o_bram_porta_en   <= 1'b1;
                    o_bram_porta_we   <= 8'hFF;
                    o_bram_porta_addr <= wr_addr;
                    o_bram_porta_din  <= '0;
                    if (!pad_more) state <= S_HDR;
                end
                S_HDR: begin
                    o_bram_porta_en   <= 1'b1;
                    o_bram_porta_we   <= 8'hFF;
                    o_bram_porta_addr <= rec_base;
                    o_bram_porta_din  <= rec_header(byte_len);
                    byte_len          <= '0;
                    if (last_rec) begin
                        state <= S_COMMIT;
                    end else begin
                        pkt.pkt_ready <= 1'b1;
                        state         <= S_RECV;
                    end
                end
                S_COMMIT: begin
                    o_bram_porta_en   <= 1'b1;
                    o_bram_porta_we   <= 8'hFF;
                    o_bram_porta_addr <= '0;
                    o_bram_porta_din  <= batch_header(flow_num);
                    state             <= S_WAITCALC;
                end
                // The first result read is issued on the falling edge so data lands two cycles into READRES.
                S_WAITCALC: begin
                    o_bram_porta_we <= '0;
                    if (calc_q && !i_calc_complete) begin
                        o_bram_porta_en   <= 1'b1;
                        o_bram_porta_addr <= RESULT_BASE;
                        rd_step           <= '0;
                        state             <= S_READRES;
                    end else begin
                        o_bram_porta_en <= 1'b0;
                    end
                end
                S_READRES: begin
                    if (rd_step < 3'd3) begin
                        o_bram_porta_en   <= 1'b1;
                        o_bram_porta_addr <= RESULT_BASE + ADDR_WIDTH'(rd_step + 3'd1);
                    end else begin
                        o_bram_porta_en <= 1'b0;
                    end
                    if (rd_step != 3'd0) begin
                        o_result       <= i_bram_porta_dout;
                        o_result_valid <= 1'b1;
                        o_result_idx   <= rd_step[1:0] - 2'd1;
                    end
                    if (rd_step == 3'd4) state <= S_DONE;
                    rd_step <= rd_step + 3'd1;
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_batch_load_engine.sv
// Self-checking bench: BRAM model, queue-based write/read/result model, directed batches.
module tb_batch_load_engine;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_batch_start = 1'b0;
    logic [7:0]  i_batch_flow_num = 8'd0;
    logic [15:0] bram_addr;
    logic [63:0] bram_din;
    logic        bram_en;
    logic [7:0]  bram_we;
    logic [63:0] bram_dout = 64'd0;
    logic        calc = 1'b0;
    logic [63:0] result;
    logic        result_valid;
    logic [1:0]  result_idx;
    logic        busy;
    logic        trunc;

    int n_checks = 0;
    int n_err    = 0;

    batch_load_engine_if pkt_if();

    always #5 i_clk = ~i_clk;

    batch_load_engine dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_batch_start     (i_batch_start),
        .i_batch_flow_num  (i_batch_flow_num),
        .pkt               (pkt_if),
        .o_bram_porta_addr (bram_addr),
        .o_bram_porta_din  (bram_din),
        .o_bram_porta_en   (bram_en),
        .o_bram_porta_we   (bram_we),
        .i_bram_porta_dout (bram_dout),
        .i_calc_complete   (calc),
        .o_result          (result),
        .o_result_valid    (result_valid),
        .o_result_idx      (result_idx),
        .o_busy            (busy),
        .o_trunc           (trunc)
    );

    // BRAM port A model, read-first, one-cycle latency; bench preloads take priority.
    logic [63:0] mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'd0;
    logic [63:0] pl_data = 64'd0;
    always @(posedge i_clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bram_en) begin
            bram_dout <= mem[bram_addr];
            if (bram_we == 8'hFF) mem[bram_addr] <= bram_din;
        end
    end

    typedef struct { logic [15:0] addr; logic [63:0] data; } wr_t;
    typedef struct { logic [1:0] idx; logic [63:0] val; } res_t;
    wr_t         wq[$];
    logic [15:0] rq[$];
    res_t        resq[$];
    int          m_rec, m_total;
    logic [7:0]  m_flow;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [63:0] act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    function automatic logic [63:0] exp_rec_hdr(input int len);
        return (64'(len) << 32) | 64'h55;
    endfunction

    function automatic logic [63:0] exp_batch_hdr(input logic [7:0] flow);
        return (64'(flow) << 16) | 64'h55;
    endfunction

    task automatic push_write(input logic [15:0] a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    // Compare process: every BRAM access and every result strobe is checked against the model queues.
    always @(negedge i_clk) begin
        wr_t  e;
        res_t r;
        if (i_rst_n) begin
            if (bram_en) begin
                if (bram_we == 8'hFF) begin
                    if (wq.size() == 0) fail_evt("unexpected_write", 64'(bram_addr));
                    else begin
                        e = wq.pop_front();
                        check("wr_addr", 64'(bram_addr), 64'(e.addr));
                        check("wr_data", bram_din, e.data);
                    end
                end else if (bram_we == 8'h00) begin
                    if (rq.size() == 0) fail_evt("unexpected_read", 64'(bram_addr));
                    else check("rd_addr", 64'(bram_addr), 64'(rq.pop_front()));
                end else fail_evt("partial_we", 64'(bram_we));
            end
            if (result_valid) begin
                if (resq.size() == 0) fail_evt("unexpected_result", result);
                else begin
                    r = resq.pop_front();
                    check("result_idx", 64'(result_idx), 64'(r.idx));
                    check("result_val", result, r.val);
                end
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [63:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge i_clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic start_batch(input logic [7:0] flow);
        m_flow  = flow;
        m_total = (int'(flow) + 1) * 5;
        m_rec   = 0;
        push_write(16'h0, 64'h0);
        i_batch_start    = 1'b1;
        i_batch_flow_num = flow;
        @(posedge i_clk);
        #1 i_batch_start = 1'b0;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t;
        pkt_if.pkt_data  = d;
        pkt_if.pkt_keep  = k;
        pkt_if.pkt_last  = l;
        pkt_if.pkt_valid = 1'b1;
        t = 0;
        @(negedge i_clk);
        while (!pkt_if.pkt_ready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 100) fail_evt("beat_timeout", d);
        @(posedge i_clk);
        #1;
        pkt_if.pkt_valid = 1'b0;
        pkt_if.pkt_last  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [7:0] last_keep, input logic [31:0] tag);
        int base, len;
        logic [7:0] k;
        base = 1 + 9 * m_rec;
        len  = 0;
        for (int w = 0; w < n; w++) begin
            k = (w == n - 1) ? last_keep : 8'hFF;
            len += $countones(k);
            if (len > 64) len = 64;
            if (w < 8) push_write(16'(base + 1 + w), {tag, 32'(w)});
        end
`ifdef BATCH_LOAD_PAD_EN
        for (int w = n; w < 8; w++) push_write(16'(base + 1 + w), 64'h0);
`endif
        push_write(16'(base), exp_rec_hdr(len));
        m_rec++;
        if (m_rec == m_total) push_write(16'h0, exp_batch_hdr(m_flow));
        for (int w = 0; w < n; w++)
            drive_beat({tag, 32'(w)}, (w == n - 1) ? last_keep : 8'hFF, w == n - 1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (wq.size() != 0 && t < 400) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 400) fail_evt("drain_timeout", 64'(wq.size()));
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_calc();
        int first, last, cnt;
        logic [63:0] vals [4];
        res_t r;
        vals[0] = 64'd1;
        vals[1] = 64'd2;
        vals[2] = 64'd3;
        vals[3] = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            rq.push_back(16'hFFFC + 16'(i));
            r.idx = 2'(i);
            r.val = vals[i];
            resq.push_back(r);
        end
        calc = 1'b1;
        repeat (4) @(posedge i_clk);
        #1 calc = 1'b0;
        first = -1;
        last  = -1;
        cnt   = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (result_valid) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
        end
        check("res_first_cycle", 64'(first), 64'd3);
        check("res_last_cycle", 64'(last), 64'd6);
        check("res_strobes", 64'(cnt), 64'd4);
        check("busy_after_done", 64'(busy), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    int         nb [10] = '{3, 10, 1, 8, 2, 1, 4, 1, 1, 6};
    logic [7:0] kb [10] = '{8'h0F, 8'hFF, 8'h00, 8'hFF, 8'h01, 8'hFF, 8'h3F, 8'h07, 8'hFF, 8'h7F};

    initial begin
        #250000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_if.pkt_data  = 64'd0;
        pkt_if.pkt_keep  = 8'd0;
        pkt_if.pkt_valid = 1'b0;
        pkt_if.pkt_last  = 1'b0;
        #2 i_rst_n = 1'b0;
        #10;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(pkt_if.pkt_ready), 64'd0);
        check("rst_en_we", 64'({bram_en, bram_we}), 64'd0);
        check("rst_addr_din", 64'(bram_addr) | bram_din, 64'd0);
        check("rst_result", result | 64'({result_valid, result_idx, trunc}), 64'd0);
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        preload(16'hFFFC, 64'd1);
        preload(16'hFFFD, 64'd2);
        preload(16'hFFFE, 64'd3);
        preload(16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFE);

        // Batch A: one flow, five full 8-beat packets.
        start_batch(8'd0);
        check("busy_in_batch", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) send_pkt(8, 8'hFF, 32'hA000_0000 + 32'(i));
        wait_drain();
        check("A_rec0_hdr", mem[1], 64'h0000_0040_0000_0055);
        check("A_rec2_hdr", mem[19], 64'h0000_0040_0000_0055);
        check("A_rec4_hdr", mem[37], 64'h0000_0040_0000_0055);
        check("A_word0", mem[0], 64'h0000_0000_0000_0055);
        check("A_trunc", 64'(trunc), 64'd0);
        run_calc();

        // Batch B: two flows, mixed lengths, truncation, and a stray start during RECV.
        for (int i = 5; i <= 9; i++) preload(16'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
        start_batch(8'd1);
        @(posedge i_clk);
        #1;
        i_batch_start    = 1'b1;
        i_batch_flow_num = 8'h07;
        @(posedge i_clk);
        #1;
        i_batch_start    = 1'b0;
        i_batch_flow_num = 8'h00;
        for (int i = 0; i < 10; i++) send_pkt(nb[i], kb[i], 32'hB000_0000 + 32'(i));
        wait_drain();
        check("B_rec0_len20", mem[1], 64'h0000_0014_0000_0055);
        check("B_rec1_trunc_len", mem[10], 64'h0000_0040_0000_0055);
        check("B_rec2_zero_len", mem[19], 64'h0000_0000_0000_0055);
        check("B_word0", mem[0], 64'h0000_0000_0001_0055);
        check("B_trunc", 64'(trunc), 64'd1);
        for (int i = 5; i <= 9; i++)
`ifdef BATCH_LOAD_PAD_EN
            check("B_pad_word", mem[i], 64'h0);
`else
            check("B_unpadded_word", mem[i], 64'hA5A5_0000_0000_0000 + 64'(i));
`endif
        run_calc();

        // Batch C: abandoned by asynchronous reset mid-packet.
        start_batch(8'd0);
        check("C_trunc_cleared", 64'(trunc), 64'd0);
        push_write(16'd2, 64'hC000_0000_0000_0000);
        push_write(16'd3, 64'hC000_0000_0000_0001);
        drive_beat(64'hC000_0000_0000_0000, 8'hFF, 1'b0);
        drive_beat(64'hC000_0000_0000_0001, 8'hFF, 1'b0);
        @(posedge i_clk);
        @(posedge i_clk);
        check("C_writes_done", 64'(wq.size()), 64'd0);
        check("C_ready_before_rst", 64'(pkt_if.pkt_ready), 64'd1);
        #3 i_rst_n = 1'b0;
        #1;
        check("C_rst_busy", 64'(busy), 64'd0);
        check("C_rst_ready", 64'(pkt_if.pkt_ready), 64'd0);
        check("C_rst_port", 64'({bram_en, bram_we}) | 64'(bram_addr) | bram_din, 64'd0);
        wq.delete();
        rq.delete();
        resq.delete();
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Batch D: fresh batch after reset, short 3-byte packets.
        start_batch(8'd0);
        for (int i = 0; i < 5; i++) send_pkt(1, 8'h07, 32'hD000_0000 + 32'(i));
        wait_drain();
        check("D_rec0_hdr", mem[1], 64'h0000_0003_0000_0055);
        check("D_rec4_hdr", mem[37], 64'h0000_0003_0000_0055);
        check("D_word0", mem[0], 64'h0000_0000_0000_0055);
        check("D_trunc", 64'(trunc), 64'd0);

        repeat (3) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/batch_load_engine.md
# batch_load_engine

Producer side of the entropy-batch BRAM. Accepts packet beats on a ready/valid stream, writes them into BRAM port A in the batch record layout that the port-B mover consumes, and commits the batch by writing the magic header word last. After the entropy calculator signals completion, it reads the four arbitration-result words back from the top of the BRAM and presents them upstream.

## Interface
- DATA_WIDTH, 64, BRAM word and stream beat width; fixed at 64 for this layout
- DATA_DEPTH, 65536, BRAM depth in words; address width = $clog2(DATA_DEPTH) = 16
- PKTS_PER_FLOW, 5, packet records per flow
- PKT_WORDS, 8, payload words per packet record
- i_clk  in  1  sole clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_batch_start  in  1  single-cycle pulse; accepted only in IDLE
- i_batch_flow_num  in  8  number of flows minus one; sampled with i_batch_start
- i_pkt_data  in  64  packet beat
- i_pkt_keep  in  8  byte-valid mask, contiguous from bit 0
- i_pkt_valid  in  1  beat valid
- i_pkt_last  in  1  last beat of packet
- o_pkt_ready  out  1  beat accepted when valid && ready
- o_bram_porta_addr  out  16  BRAM address
- o_bram_porta_din  out  64  write data
- o_bram_porta_en  out  1  port enable
- o_bram_porta_we  out  8  byte write enables; all-ones or zero
- i_bram_porta_dout  in  64  read data, 1-cycle latency
- i_calc_complete  in  1  level from calculator; high while results are written
- o_result  out  64  result word
- o_result_valid  out  1  one-cycle strobe per result word
- o_result_idx  out  2  result word index 0..3 (address 0xFFFC+idx)
- o_busy  out  1  high in every state except IDLE
- o_trunc  out  1  sticky; set when any packet exceeds PKT_WORDS beats, cleared on batch start

## Operation
- Layout: word 0 = batch header {[23:16] flow_num, [7:0] 8'h55}. Record k (k = 0..(flow_num+1)*PKTS_PER_FLOW-1) at base 1+k*(1+PKT_WORDS): header {[39:32] byte length, [7:0] 8'h55}, then PKT_WORDS payload words.
- States: IDLE, CLEAR, RECV, PAD, HDR, COMMIT, WAITCALC, READRES, DONE.
- IDLE: on i_batch_start, latch flow_num, record total = (flow_num+1)*PKTS_PER_FLOW (11-bit), clear o_trunc, go CLEAR.
- CLEAR: write 64'h0 to word 0 (invalidates stale batch for the reader), go RECV.
- RECV: o_pkt_ready=1. Beat w (w<PKT_WORDS) written to base+1+w; byte length += popcount(keep), saturating at 8'd64. Beats w>=PKT_WORDS accepted, not written, set o_trunc. On last beat: PAD if w+1<PKT_WORDS and macro defined, else HDR.
- PAD: one zero write per cycle until PKT_WORDS payload words written; then HDR.
- HDR: write record header at base; advance record; RECV if records remain, else COMMIT.
- COMMIT: write word 0 batch header; go WAITCALC.
- WAITCALC: port disabled; on falling edge of i_calc_complete (registered copy high, input low) go READRES.
- READRES: issue reads 0xFFFC..0xFFFF on consecutive cycles; each dout captured one cycle later to o_result with o_result_idx; go DONE after last capture.
- DONE: one cycle, go IDLE.
- i_batch_start outside IDLE ignored.

## Timing
- Reset: all outputs 0, state IDLE; asynchronous assertion mid-batch abandons it (word 0 left as last written; next batch CLEAR overwrites).
- All outputs registered. One BRAM access per cycle; every write has en=1, we=8'hFF.
- o_pkt_ready falls the cycle after last beat accepted; minimum packet-to-packet gap 2 cycles (HDR) without padding.
- o_result_valid first strobe 2 cycles after entering READRES; four strobes back-to-back.
- Zero-length packet (single beat, keep=0): length 0, record written normally.

## Configuration
- BATCH_LOAD_PAD_EN defined: PAD state zero-fills unused payload words. Undefined: PAD omitted, unused payload words keep prior contents; reader bounds on header length.

## Structure
- Shared package: magic 8'h55, result base 16'hFFFC, header field bit positions, state encoding, record stride constant.
- One sub-module natural: batch_load_addr_gen (record base/word offset counters, record-remaining compare).

## Test plan
- flow_num=0, five 8-beat full-keep packets -> records at 1,10,19,28,37 with length 64; word 0 = 64'h0000_0000_0000_0055 written last.
- 3-beat packet, last keep=8'h0F -> length 20; with PAD_EN words base+4..base+8 = 0.
- 10-beat packet -> only 8 written, length 64, o_trunc=1, next record base unaffected.
- Pulse i_calc_complete 4 cycles, BRAM preloaded 0xFFFC..0xFFFF = 1,2,3,64'hFFFF_FFFF_FFFF_FFFE -> four o_result_valid strobes idx 0..3 with those values.
- i_batch_start during RECV -> ignored, no extra CLEAR write.
- Async reset mid-RECV -> all outputs 0 immediately; new batch starts with CLEAR writing 0 to word 0.
